// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// The optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit combinational full adder: the only arithmetic in the serial adder.
module serial_fa_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder around a single full-adder cell, with start/busy/done handshake.
// Defining SERIAL_ADDER_SUB_EN adds the sub port (a - b via ~b and forced carry-in).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one bit pair per clock, LSB first
// DONE  | one-cycle done pulse; start here reloads immediately
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic             cell_s, cell_c;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic [WIDTH-1:0] ps_next;

    serial_fa_cell u_cell (
        .x (a_sh_q[0]),
        .y (b_sh_q[0]),
        .z (carry_q),
        .s (cell_s),
        .c (cell_c)
    );

    // Subtraction is a + ~b + 1, so cin is ignored when sub is captured.
    always_comb begin
        b_load = b;
        c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load = ~b;
            c_load = 1'b1;
        end
`endif
    end

    assign ps_next = {cell_s, ps_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        ps_d    = ps_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                ps_d    = ps_next;
                carry_d = cell_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    sum_d   = ps_next;
                    cout_d  = cell_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            ps_q    <= ps_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8) with a result scoreboard.
// Subtract cases run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int W = 8;
    localparam int PERIOD = 10;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic [W:0] sb[$];
    int         total;
    int         passed;
    time        t_start;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #(PERIOD/2) clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cv, input logic sv);
        logic [W-1:0] nb;
        nb = ~bv;
        if (sv) return {1'b0, av} + {1'b0, nb} + (W+1)'(1);
        return {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    endfunction

    // Drives a start at a negedge; returns 1ns after the accepting edge.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic sv, input bit push);
        @(negedge clk);
        a = av;
        b = bv;
        cin = cv;
`ifdef SERIAL_ADDER_SUB_EN
        sub = sv;
`endif
        start = 1'b1;
        if (push) sb.push_back(model(av, bv, cv, sv));
        @(posedge clk);
        t_start = $time;
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * W; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_result(input string tag);
        logic [W:0] exp;
        exp = '0;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) exp = sb.pop_front();
        chk({tag, "_result"}, 32'({cout, sum}), 32'(exp));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic sv);
        bit ok;
        launch(av, bv, cv, sv, 1'b1);
        wait_done(ok);
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
        check_result(tag);
    endtask

    initial begin
        bit  ok;
        int  lat;
        time t1;
        int  dcount;

        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;

        // Zero operands: latency, busy and one-cycle done pulse
        launch(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("zero_busy_run", 32'(busy), 32'd1);
        chk("zero_done_run", 32'(done), 32'd0);
        wait_done(ok);
        chk("zero_done_seen", 32'(ok), 32'd1);
        lat = int'(($time - t_start) / PERIOD);
        chk("zero_latency", 32'(lat), 32'(W));
        chk("zero_busy_at_done", 32'(busy), 32'd0);
        check_result("zero");
        @(negedge clk);
        chk("zero_done_pulse_width", 32'(done), 32'd0);

        run_op("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op("a5_5a_c1", 8'hA5, 8'h5A, 1'b1, 1'b0);

        // Start pulse with new operands mid-RUN must be ignored
        launch(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        chk("ignore_done_seen", 32'(ok), 32'd1);
        check_result("ignore");
        repeat (2) @(negedge clk);
        chk("ignore_no_second_done", 32'(done), 32'd0);

        // Start held across DONE: back-to-back operations
        @(negedge clk);
        a = 8'h80;
        b = 8'h80;
        cin = 1'b0;
        start = 1'b1;
        sb.push_back(model(8'h80, 8'h80, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        a = 8'h01;
        b = 8'h02;
        sb.push_back(model(8'h01, 8'h02, 1'b0, 1'b0));
        wait_done(ok);
        chk("b2b_first_done", 32'(ok), 32'd1);
        t1 = $time;
        check_result("b2b_first");
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(ok);
        chk("b2b_second_done", 32'(ok), 32'd1);
        chk("b2b_gap", 32'(int'(($time - t1) / PERIOD)), 32'(W + 1));
        check_result("b2b_second");

        // Asynchronous reset during the 4th RUN cycle
        launch(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sum",  32'(sum),  32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("midrst_no_done", 32'(dcount), 32'd0);

        for (int i = 0; i < 4; i++) begin
            run_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_5_7", 8'h05, 8'h07, 1'b0, 1'b1);
        run_op("sub_7_5", 8'h07, 8'h05, 1'b1, 1'b1);
        run_op("sub_off", 8'h07, 8'h05, 1'b1, 1'b0);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
